// File: rtl/code_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | code_sequencer_if : load stream, instruction stream and storage bus      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface code_sequencer_if #(
  parameter int CODE_SIZE = 12
) ();
  logic                 load_valid;
  logic                 load_last;
  logic [CODE_SIZE-1:0] load_data;
  logic                 load_ready;

  logic                 instr_valid;
  logic                 instr_ready;
  logic [CODE_SIZE-1:0] instr_data;
  logic [31:0]          instr_index;

  logic                 st_active;
  logic                 st_reset;
  logic                 st_is_write;
  logic [31:0]          st_write_line;
  logic [CODE_SIZE-1:0] st_write_data;
  logic [CODE_SIZE-1:0] st_code;
  logic [31:0]          st_code_index;

  // master: the sequencer itself
  modport master (
    input  load_valid, load_last, load_data,
    output load_ready,
    output instr_valid, instr_data, instr_index,
    input  instr_ready,
    output st_active, st_reset, st_is_write, st_write_line, st_write_data,
    input  st_code, st_code_index
  );

  // slave: host, datapath and storage seen from the outside
  modport slave (
    output load_valid, load_last, load_data,
    input  load_ready,
    input  instr_valid, instr_data, instr_index,
    output instr_ready,
    input  st_active, st_reset, st_is_write, st_write_line, st_write_data,
    output st_code, st_code_index
  );
endinterface
`default_nettype wire

// File: rtl/code_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | code_sequencer : loads a program into code storage, then steps through   |
// | it issuing code words to the datapath until program end or halt word.    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module code_sequencer #(
  parameter int                   CODE_SIZE     = 12,
  parameter int                   MAX_CODE_LINE = 100,
  parameter logic [CODE_SIZE-1:0] HALT_CODE     = '1
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        load_start,
  input  wire logic        run_start,
  input  wire logic        abort,
  output      logic        busy,
  output      logic        done,
  output      logic        halted,
  output      logic        error,
  output      logic [31:0] prog_len,
  code_sequencer_if.master bus
);

  localparam logic [31:0] c_max_line = 32'(MAX_CODE_LINE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_wr_ptr;
  logic [31:0] w_wr_ptr_next;
  logic [31:0] r_prog_len;
  logic [31:0] w_prog_len_next;
  logic        r_halted;
  logic        w_halted_next;
  logic        r_error;
  logic        w_error_next;

  logic        w_load_ready;
  logic        w_write;
  logic        w_instr_valid;
  logic        w_st_active;
  logic        w_run_go;
  logic        w_is_halt;
  logic        w_end;

  assign w_is_halt = (bus.st_code == HALT_CODE);
  assign w_end     = (bus.st_code_index >= r_prog_len) || w_is_halt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= 32'd0;
      r_prog_len <= 32'd0;
      r_halted   <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wr_ptr   <= w_wr_ptr_next;
      r_prog_len <= w_prog_len_next;
      r_halted   <= w_halted_next;
      r_error    <= w_error_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_wr_ptr_next   = r_wr_ptr;
    w_prog_len_next = r_prog_len;
    w_halted_next   = r_halted;
    w_error_next    = 1'b0;
    w_load_ready    = 1'b0;
    w_write         = 1'b0;
    w_instr_valid   = 1'b0;
    w_st_active     = 1'b0;
    w_run_go        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (load_start) begin
          w_state_next  = S_LOAD;
          w_wr_ptr_next = 32'd0;
        end else if (run_start) begin
          if (r_prog_len != 32'd0) begin
            w_state_next  = S_RUN;
            w_run_go      = 1'b1;
            w_halted_next = 1'b0;
          end else begin
            w_error_next  = 1'b1;
          end
        end
      end

      S_LOAD: begin
        // ready drops during abort so the host never sees a handshake that wrote nothing
        w_load_ready = (r_wr_ptr < c_max_line) && !abort;
        if (abort) begin
          w_state_next = S_IDLE;
        end else if (r_wr_ptr >= c_max_line) begin
          w_prog_len_next = c_max_line;
          w_error_next    = 1'b1;
          w_state_next    = S_IDLE;
        end else if (bus.load_valid) begin
          w_write       = 1'b1;
          w_wr_ptr_next = r_wr_ptr + 32'd1;
          if (bus.load_last) begin
            w_prog_len_next = r_wr_ptr + 32'd1;
            w_state_next    = S_IDLE;
          end
        end
      end

      S_RUN: begin
        if (abort) begin
          w_state_next = S_IDLE;
        end else if (w_end) begin
          w_state_next  = S_DONE;
          w_halted_next = w_is_halt && (bus.st_code_index < r_prog_len);
        end else begin
          w_instr_valid = 1'b1;
          w_st_active   = bus.instr_ready;
        end
      end

      S_DONE: begin
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // every output except st_reset is forced low while reset is held
  assign bus.load_ready    = !reset && w_load_ready;
  assign bus.st_is_write   = !reset && w_write;
  assign bus.st_write_line = (!reset && w_write) ? r_wr_ptr : 32'd0;
  assign bus.st_write_data = (!reset && w_write) ? bus.load_data : '0;

  assign bus.instr_valid   = !reset && w_instr_valid;
  assign bus.instr_data    = (!reset && r_state == S_RUN) ? bus.st_code : '0;
  assign bus.instr_index   = (!reset && r_state == S_RUN) ? bus.st_code_index : 32'd0;

  assign bus.st_active     = !reset && w_st_active;
  assign bus.st_reset      = reset || w_run_go;

  assign busy     = !reset && (r_state != S_IDLE);
  assign done     = !reset && (r_state == S_DONE);
  assign halted   = !reset && r_halted;
  assign error    = !reset && r_error;
  assign prog_len = reset ? 32'd0 : r_prog_len;

endmodule
`default_nettype wire

// File: tb/tb_code_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_code_sequencer : directed self-checking bench with a code storage     |
// | model behind the sequencer. Revision 1.0                                 |
// +--------------------------------------------------------------------------+
module tb_code_sequencer;

  localparam int c_code_size = 12;
  localparam int c_max_line  = 4;

  logic        clk;
  logic        reset;
  logic        load_start;
  logic        run_start;
  logic        abort;
  logic        busy;
  logic        done;
  logic        halted;
  logic        error;
  logic [31:0] prog_len;

  int n_checks;
  int n_fail;

  code_sequencer_if #(.CODE_SIZE(c_code_size)) bus ();

  code_sequencer #(
    .CODE_SIZE    (c_code_size),
    .MAX_CODE_LINE(c_max_line),
    .HALT_CODE    (12'hFFF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_start(load_start),
    .run_start (run_start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .halted    (halted),
    .error     (error),
    .prog_len  (prog_len),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // code storage: counter plus memory with a combinational read port
  logic [11:0] r_mem [16];
  logic [31:0] r_cnt;

  assign bus.st_code       = (r_cnt < 32'd16) ? r_mem[r_cnt[3:0]] : 12'h000;
  assign bus.st_code_index = r_cnt;

  always @(posedge clk) begin
    if (bus.st_reset) r_cnt <= 32'd0;
    else if (bus.st_active) r_cnt <= r_cnt + 32'd1;
    if (bus.st_is_write) r_mem[bus.st_write_line[3:0]] <= bus.st_write_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    #1;
    n_checks++;
    if ({bus.st_reset, busy, bus.load_ready, bus.st_is_write, bus.instr_valid, done, error, halted, prog_len}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got st_reset=%b busy=%b ready=%b wr=%b iv=%b done=%b err=%b halt=%b len=%0d want 1,0,0,0,0,0,0,0,0",
               bus.st_reset, busy, bus.load_ready, bus.st_is_write, bus.instr_valid, done, error, halted, prog_len);
    end
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.st_reset, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_release: got st_reset=%b busy=%b want 0 0", bus.st_reset, busy);
    end
    tick();
  endtask

  task automatic test_empty_run();
    run_start = 1'b1;
    #1;
    n_checks++;
    if ({bus.st_reset, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL empty_run_start: got st_reset=%b busy=%b want 0 0", bus.st_reset, busy);
    end
    tick();
    run_start = 1'b0;
    #1;
    n_checks++;
    if ({error, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL empty_run_error: got error=%b busy=%b want 1 0", error, busy);
    end
    tick();
    #1;
    n_checks++;
    if (error !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_run_pulse: got error=%b want 0", error);
    end
    tick();
  endtask

  task automatic test_load(input logic [11:0] d0, input logic [11:0] d1, input logic [11:0] d2);
    logic [11:0] d [3];
    d[0] = d0; d[1] = d1; d[2] = d2;
    load_start = 1'b1;
    #1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = d[i];
      bus.load_last  = (i == 2);
      #1;
      n_checks++;
      if ({bus.load_ready, bus.st_is_write, bus.st_write_line, bus.st_write_data} !== {1'b1, 1'b1, 32'(i), d[i]}) begin
        n_fail++;
        $display("FAIL load_word%0d: got ready=%b wr=%b line=%0d data=%h want 1 1 %0d %h",
                 i, bus.load_ready, bus.st_is_write, bus.st_write_line, bus.st_write_data, i, d[i]);
      end
      tick();
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    #1;
    n_checks++;
    if ({busy, prog_len} !== {1'b0, 32'd3}) begin
      n_fail++;
      $display("FAIL load_end: got busy=%b prog_len=%0d want 0 3", busy, prog_len);
    end
    tick();
  endtask

  task automatic test_run_basic();
    logic [11:0] exp_d [3];
    exp_d[0] = 12'h005; exp_d[1] = 12'h006; exp_d[2] = 12'h007;
    bus.instr_ready = 1'b1;
    run_start = 1'b1;
    #1;
    n_checks++;
    if (bus.st_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL run_st_reset: got %b want 1", bus.st_reset);
    end
    tick();
    run_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if ({bus.instr_valid, bus.instr_index, bus.instr_data, bus.st_active, done} !== {1'b1, 32'(k), exp_d[k], 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL run_issue%0d: got v=%b idx=%0d data=%h act=%b done=%b want 1 %0d %h 1 0",
                 k, bus.instr_valid, bus.instr_index, bus.instr_data, bus.st_active, done, k, exp_d[k]);
      end
      tick();
    end
    #1;
    n_checks++;
    if ({bus.instr_valid, bus.st_active, done, busy} !== 4'b0001) begin
      n_fail++;
      $display("FAIL run_end: got v=%b act=%b done=%b busy=%b want 0 0 0 1", bus.instr_valid, bus.st_active, done, busy);
    end
    tick();
    #1;
    n_checks++;
    if ({done, halted, busy} !== 3'b101) begin
      n_fail++;
      $display("FAIL run_done: got done=%b halted=%b busy=%b want 1 0 1", done, halted, busy);
    end
    tick();
    #1;
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL run_idle: got done=%b busy=%b want 0 0", done, busy);
    end
    tick();
  endtask

  task automatic test_halt();
    int n_active;
    n_active = 0;
    test_load(12'h005, 12'hFFF, 12'h007);
    bus.instr_ready = 1'b1;
    run_start = 1'b1;
    #1;
    if (bus.st_active) n_active++;
    tick();
    run_start = 1'b0;
    #1;
    if (bus.st_active) n_active++;
    n_checks++;
    if ({bus.instr_valid, bus.instr_index, bus.instr_data} !== {1'b1, 32'd0, 12'h005}) begin
      n_fail++;
      $display("FAIL halt_issue0: got v=%b idx=%0d data=%h want 1 0 005", bus.instr_valid, bus.instr_index, bus.instr_data);
    end
    tick();
    #1;
    if (bus.st_active) n_active++;
    n_checks++;
    if (bus.instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_not_issued: got instr_valid=%b data=%h want 0", bus.instr_valid, bus.instr_data);
    end
    tick();
    #1;
    if (bus.st_active) n_active++;
    n_checks++;
    if ({done, halted} !== 2'b11) begin
      n_fail++;
      $display("FAIL halt_done: got done=%b halted=%b want 1 1", done, halted);
    end
    tick();
    #1;
    n_checks++;
    if ({done, busy, halted, 32'(n_active)} !== {1'b0, 1'b0, 1'b1, 32'd1}) begin
      n_fail++;
      $display("FAIL halt_after: got done=%b busy=%b halted=%b st_active_pulses=%0d want 0 0 1 1", done, busy, halted, n_active);
    end
    tick();
  endtask

  task automatic test_backpressure();
    test_load(12'h005, 12'h006, 12'h007);
    bus.instr_ready = 1'b1;
    run_start = 1'b1;
    #1;
    tick();
    run_start = 1'b0;
    #1;
    n_checks++;
    if ({bus.instr_valid, bus.instr_index, bus.instr_data, bus.st_active, halted} !== {1'b1, 32'd0, 12'h005, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_first: got v=%b idx=%0d data=%h act=%b halted=%b want 1 0 005 1 0",
               bus.instr_valid, bus.instr_index, bus.instr_data, bus.st_active, halted);
    end
    tick();
    for (int s = 0; s < 2; s++) begin
      bus.instr_ready = 1'b0;
      #1;
      n_checks++;
      if ({bus.instr_valid, bus.instr_index, bus.instr_data, bus.st_active} !== {1'b1, 32'd1, 12'h006, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_stall%0d: got v=%b idx=%0d data=%h act=%b want 1 1 006 0",
                 s, bus.instr_valid, bus.instr_index, bus.instr_data, bus.st_active);
      end
      tick();
    end
    bus.instr_ready = 1'b1;
    #1;
    n_checks++;
    if ({bus.instr_valid, bus.instr_index, bus.instr_data, bus.st_active} !== {1'b1, 32'd1, 12'h006, 1'b1}) begin
      n_fail++;
      $display("FAIL bp_resume: got v=%b idx=%0d data=%h act=%b want 1 1 006 1",
               bus.instr_valid, bus.instr_index, bus.instr_data, bus.st_active);
    end
    tick();
    #1;
    n_checks++;
    if ({bus.instr_valid, bus.instr_index, bus.instr_data} !== {1'b1, 32'd2, 12'h007}) begin
      n_fail++;
      $display("FAIL bp_last: got v=%b idx=%0d data=%h want 1 2 007", bus.instr_valid, bus.instr_index, bus.instr_data);
    end
    tick();
    #1;
    tick();
    #1;
    n_checks++;
    if ({done, halted} !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_done: got done=%b halted=%b want 1 0", done, halted);
    end
    tick();
  endtask

  task automatic test_overflow();
    load_start = 1'b1;
    #1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.load_valid = 1'b1;
      bus.load_last  = 1'b0;
      bus.load_data  = 12'(12'h101 + i);
      #1;
      n_checks++;
      if ({bus.load_ready, bus.st_is_write, bus.st_write_line, bus.st_write_data} !== {1'b1, 1'b1, 32'(i), 12'(12'h101 + i)}) begin
        n_fail++;
        $display("FAIL ovf_word%0d: got ready=%b wr=%b line=%0d data=%h want 1 1 %0d %h",
                 i, bus.load_ready, bus.st_is_write, bus.st_write_line, bus.st_write_data, i, 12'(12'h101 + i));
      end
      tick();
    end
    bus.load_data = 12'h105;
    #1;
    n_checks++;
    if ({bus.load_ready, bus.st_is_write, busy, error} !== 4'b0010) begin
      n_fail++;
      $display("FAIL ovf_full: got ready=%b wr=%b busy=%b error=%b want 0 0 1 0", bus.load_ready, bus.st_is_write, busy, error);
    end
    tick();
    bus.load_valid = 1'b0;
    #1;
    n_checks++;
    if ({error, busy, prog_len} !== {1'b1, 1'b0, 32'd4}) begin
      n_fail++;
      $display("FAIL ovf_error: got error=%b busy=%b prog_len=%0d want 1 0 4", error, busy, prog_len);
    end
    tick();
    #1;
    n_checks++;
    if (error !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_pulse: got error=%b want 0", error);
    end
    tick();
  endtask

  task automatic test_abort();
    bus.instr_ready = 1'b1;
    run_start = 1'b1;
    #1;
    tick();
    run_start = 1'b0;
    #1;
    n_checks++;
    if ({bus.instr_valid, bus.instr_index, bus.instr_data} !== {1'b1, 32'd0, 12'h101}) begin
      n_fail++;
      $display("FAIL abort_issue0: got v=%b idx=%0d data=%h want 1 0 101", bus.instr_valid, bus.instr_index, bus.instr_data);
    end
    tick();
    abort = 1'b1;
    #1;
    n_checks++;
    if ({bus.instr_valid, bus.st_active} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_cycle: got v=%b act=%b want 0 0", bus.instr_valid, bus.st_active);
    end
    tick();
    abort = 1'b0;
    #1;
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%b done=%b want 0 0", busy, done);
    end
    tick();
    #1;
    n_checks++;
    if ({done, prog_len} !== {1'b0, 32'd4}) begin
      n_fail++;
      $display("FAIL abort_no_done: got done=%b prog_len=%0d want 0 4", done, prog_len);
    end
    tick();
  endtask

  task automatic test_reset_mid_load();
    load_start = 1'b1;
    #1;
    tick();
    load_start = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_last  = 1'b0;
    bus.load_data  = 12'h0AA;
    #1;
    n_checks++;
    if (bus.st_is_write !== 1'b1) begin
      n_fail++;
      $display("FAIL rml_write: got wr=%b want 1", bus.st_is_write);
    end
    tick();
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.st_reset, bus.load_ready, bus.st_is_write, busy} !== 4'b1000) begin
      n_fail++;
      $display("FAIL rml_during: got st_reset=%b ready=%b wr=%b busy=%b want 1 0 0 0",
               bus.st_reset, bus.load_ready, bus.st_is_write, busy);
    end
    tick();
    reset = 1'b0;
    bus.load_valid = 1'b0;
    #1;
    n_checks++;
    if ({busy, prog_len, bus.load_ready} !== {1'b0, 32'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL rml_after: got busy=%b prog_len=%0d ready=%b want 0 0 0", busy, prog_len, bus.load_ready);
    end
    tick();
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    reset           = 1'b1;
    load_start      = 1'b0;
    run_start       = 1'b0;
    abort           = 1'b0;
    bus.load_valid  = 1'b0;
    bus.load_last   = 1'b0;
    bus.load_data   = 12'h000;
    bus.instr_ready = 1'b0;

    test_reset();
    test_empty_run();
    test_load(12'h005, 12'h006, 12'h007);
    test_run_basic();
    test_halt();
    test_backpressure();
    test_overflow();
    test_abort();
    test_reset_mid_load();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/code_sequencer.md
Name: code_sequencer

Overview:
- Controller in front of the code storage block: loads a program into it over a valid/ready stream.
- Then runs the program by stepping the storage's code counter and issuing each code word to the execution datapath over a valid/ready handshake.
- Stops at program end or at a halt word; reports done/error to the host.

Parameters:
CODE_SIZE, 12, width of one code word
MAX_CODE_LINE, 100, storage depth in lines (valid lines 0..MAX_CODE_LINE-1)
HALT_CODE, all-ones of CODE_SIZE, code word that terminates a run (never issued)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
load_start  input  1  begin load phase (sampled in IDLE only)
load_valid  input  1  load word present
load_last  input  1  qualifies final load word
load_data  input  CODE_SIZE  load word
load_ready  output  1  sequencer accepts load word
run_start  input  1  begin execution (sampled in IDLE only)
abort  input  1  terminate LOAD or RUN, return to IDLE
instr_valid  output  1  instr_data/instr_index valid
instr_ready  input  1  datapath accepts instruction
instr_data  output  CODE_SIZE  current code word
instr_index  output  32  current code line
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at run completion
halted  output  1  set when run ended on HALT_CODE; cleared at next run_start
error  output  1  one-cycle pulse: load overflow or run with empty program
prog_len  output  32  number of lines loaded
st_active  output  1  to storage: advance code counter
st_reset  output  1  to storage: clear code counter
st_is_write  output  1  to storage: write strobe
st_write_line  output  32  to storage: write address
st_write_data  output  CODE_SIZE  to storage: write data
st_code  input  CODE_SIZE  from storage: word at current line (combinational)
st_code_index  input  32  from storage: current line

Behaviour:
- States: IDLE, LOAD, RUN, DONE. Reset -> IDLE, wr_ptr=0, prog_len=0, halted=0, done=0, error=0. While reset is high, st_reset=1 and all other outputs are 0.
- IDLE, load_start=1 -> LOAD, wr_ptr<=0. IDLE, run_start=1, prog_len>0 -> RUN. IDLE, run_start=1, prog_len==0 -> error pulse next cycle, stay IDLE. If both starts are high, load_start wins.
- LOAD:
  - load_ready = (wr_ptr < MAX_CODE_LINE).
  - On load_valid&&load_ready: st_is_write=1, st_write_line=wr_ptr, st_write_data=load_data (all combinational, same cycle); wr_ptr<=wr_ptr+1.
  - Accepted word with load_last=1: prog_len<=wr_ptr+1, -> IDLE.
  - When wr_ptr reaches MAX_CODE_LINE without a last word: prog_len<=MAX_CODE_LINE, error pulse, -> IDLE. Any further words are not accepted.
- Run start: st_reset = reset || (IDLE && run_start && prog_len>0 && !load_start). Storage counter is 0 on the next cycle. halted<=0.
- RUN:
  - end = (st_code_index >= prog_len) || (st_code == HALT_CODE).
  - instr_valid = !end. instr_data = st_code. instr_index = st_code_index.
  - st_active = instr_valid && instr_ready (counter advances one line per accepted transfer; full throughput, one per cycle).
  - Backpressure: with instr_ready=0, the counter holds, so data and index stay stable.
  - When end: -> DONE. halted<=(st_code==HALT_CODE && st_code_index<prog_len). The halt word is never issued.
- DONE: done=1 for exactly one cycle, -> IDLE. prog_len is retained, so run_start may re-run without reloading.
- abort in LOAD or RUN:
  - That cycle: no write, no instr_valid, no st_active.
  - Next state IDLE, no done pulse.
  - Aborted LOAD leaves prog_len unchanged.
- Latency: run_start at cycle N -> first instr_valid at N+1 with index 0. For prog_len=L with constant ready: issues at N+1..N+L, done at N+L+2.
- Run/load starts while busy are ignored.
- Reset mid-operation: reset takes effect at the next edge regardless of state.

Test Plan:
- Load [0x005,0x006,0x007] with load_last on the third word, valid every cycle -> st_is_write on 3 consecutive cycles, lines 0,1,2; prog_len=3; busy falls.
- After the above, run_start at cycle N, instr_ready=1 -> instr_valid at N+1..N+3 with (index,data)=(0,005),(1,006),(2,007); done pulse at N+5; halted=0.
- Load [0x005,0xFFF,0x007] and run -> only 0x005 issued; done pulse; halted=1; st_active pulses exactly once.
- Run prog_len=3 with instr_ready low for 2 cycles at index 1 -> instr_data=0x006, instr_index=1 held stable; st_active=0 during the stall; completes normally.
- MAX_CODE_LINE=4: load 5 words with no load_last -> 4 writes (lines 0..3), load_ready=0 after the 4th, error pulse, prog_len=4. Separately, run_start with prog_len=0 -> error pulse, stays IDLE.
- Abort at index 1 of a run -> IDLE next cycle, no done pulse. Reset asserted mid-load -> IDLE, prog_len=0, load_ready=0.
